gpu_draw: RTL and testbench
===========================

GPU_DRAW -- requirements
Module: gpu_draw

Interface
REQ-001 SHALL have parameter CANVAS_W, default 320, meaning canvas width in pixels (multiple of 16).
REQ-002 SHALL have parameter CANVAS_H, default 64, meaning canvas height in rows.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port gpu_en  input  1  draw command strobe from the game centre.
REQ-006 SHALL have port dino_y  input  7  dino vertical offset above ground (0..127).
REQ-007 SHALL have port obstacle_x  input  9  obstacle left-edge x position (0..511).
REQ-008 SHALL have port state  input  2  game state: 00 idle, 01 run, 10 game over, 11 reserved.
REQ-009 SHALL have port fb_we  output  1  framebuffer write request (valid).
REQ-010 SHALL have port fb_addr  output  11  framebuffer word address, row*20+col.
REQ-011 SHALL have port fb_data  output  16  16 pixels, bit 15 = leftmost pixel (x = col*16).
REQ-012 SHALL have port fb_ready  input  1  framebuffer accepts the current word when high with fb_we.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not S_IDLE.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last word of a frame is accepted.

Function
REQ-015 FSM states SHALL be S_IDLE, S_DRAW, S_DONE.
REQ-016 S_IDLE with gpu_en=1 at a rising edge SHALL latch dino_y, obstacle_x, state into snapshot registers, load addr=0, and enter S_DRAW; fb_we goes high in the following cycle.
REQ-017 In S_DRAW, fb_we SHALL be 1; fb_addr/fb_data SHALL stay stable until fb_ready=1; each accepted word advances addr by 1 (col 0..19, then row+1).
REQ-018 Acceptance of word 1279 (row 63, col 19) SHALL move to S_DONE; S_DONE lasts exactly one cycle with frame_done=1 and fb_we=0, then returns to S_IDLE.
REQ-019 gpu_en during S_DRAW or S_DONE SHALL set a one-deep pending flag; further strobes while pending is set are dropped.
REQ-020 Leaving S_DONE with pending set SHALL clear pending, latch the current inputs, and enter S_DRAW directly (no idle cycle).
REQ-021 Snapshot registers SHALL NOT change during a frame; input changes mid-frame do not affect drawn pixels.
REQ-022 Ground: row 60 SHALL be all ones; rows 61..63 all zero before inversion.
REQ-023 Dino: clamp d = min(dino_y, 44); set pixels x in 16..31, rows (44-d)..(59-d) inclusive.
REQ-024 Obstacle: x in [obstacle_x, obstacle_x+7] computed in 10 bits, clipped at x<=319, rows 48..59; obstacle_x>=320 draws nothing.
REQ-025 Overlapping shapes SHALL be ORed.
REQ-026 State 00: ground and dino only; 01: ground, dino, obstacle; 10: as 01 then every bit inverted; 11: all words 16'h0000.
REQ-027 fb_data SHALL be a combinational function of snapshot and current addr only.

Reset
REQ-028 rst=0 SHALL asynchronously force S_IDLE, fb_we=0, fb_addr=0, fb_data=0, busy=0, frame_done=0, pending=0, snapshot=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no frame_done; the first post-reset gpu_en starts a new frame at addr 0.
REQ-030 While rst=0, gpu_en SHALL be ignored.

Verification
REQ-031 fb_ready=1, state=01, dino_y=0, obstacle_x=100, one gpu_en pulse -> 1280 consecutive writes addr 0..1279; addr 20*44+1 = 16'hFFFF; addr 20*48+6 = 16'h0FF0; addr 1200..1219 = 16'hFFFF; frame_done single pulse the cycle after addr 1279 accepted.
REQ-032 state=10, dino_y=36, obstacle_x=316 -> addr 8*20+1 = 16'h0000; addr 20*50+19 = 16'hFFF0; addr 1260 = 16'hFFFF.
REQ-033 fb_ready toggled pseudo-randomly -> fb_addr/fb_data never change while fb_we=1 and fb_ready=0; exactly 1280 accepted words per frame.
REQ-034 Three gpu_en pulses during one frame, dino_y changed mid-frame -> first frame uses the original snapshot; exactly one extra frame follows with no idle cycle; its dino rows reflect dino_y at restart; third pulse dropped.
REQ-035 rst driven low at addr 600 -> fb_we, busy, fb_addr drop to 0 immediately without waiting for clk; no frame_done; next gpu_en restarts at addr 0.
REQ-036 state=11, obstacle_x=511, dino_y=127 -> all 1280 words 16'h0000; with state=01 same inputs: no obstacle pixels, dino rows 0..15 at col 1.

Source files
------------

// File: rtl/gpu_draw.sv
// gpu_draw: renders one frame of the runner game into a word-organised
// framebuffer. Each frame is a raster scan of CANVAS_H rows by CANVAS_W/16
// 16-pixel words (word address = row*20 + col). Word content is derived
// combinationally from a snapshot of the game inputs taken at frame start.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - asynchronous active-low reset
//   gpu_en       - draw command strobe
//   dino_y       - dino height above ground (0..127)
//   obstacle_x   - obstacle left edge x (0..511)
//   state        - 00 idle, 01 run, 10 game over, 11 reserved (blank)
//   fb_we        - framebuffer write valid
//   fb_addr      - framebuffer word address
//   fb_data      - 16 pixels, bit 15 = leftmost
//   fb_ready     - framebuffer ready
//   busy         - FSM is not idle
//   frame_done   - one-cycle pulse after the last word is accepted
//   dbg_state_o  - FSM state (0 idle, 1 draw, 2 done)
//
// Handshake: a word transfers on a rising edge where fb_we and fb_ready are
// both high. While fb_we is high and fb_ready is low, fb_addr and fb_data hold
// their values; fb_we never drops before the word is taken.
module gpu_draw #(
  parameter int CANVAS_W = 320,
  parameter int CANVAS_H = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gpu_en,
  input  logic [6:0]  dino_y,
  input  logic [8:0]  obstacle_x,
  input  logic [1:0]  state,
  output logic        fb_we,
  output logic [10:0] fb_addr,
  output logic [15:0] fb_data,
  input  logic        fb_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  dbg_state_o
);

  localparam int COLS  = CANVAS_W / 16;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(CANVAS_H);

  // Scene geometry: dino is 16x16 standing on the row above the ground line.
  localparam int GROUND_ROW = 60;
  localparam int DINO_TOP   = 44;
  localparam int DINO_BOT   = 59;
  localparam int OBST_TOP   = 48;
  localparam int OBST_BOT   = 59;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  fsm_e             fsm_q;
  logic             fb_we_q;
  logic             frame_done_q;
  logic             pending_q;
  logic [6:0]       snap_dy_q;
  logic [8:0]       snap_ox_q;
  logic [1:0]       snap_st_q;
  logic [10:0]      addr_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  logic start;
  logic last_word;

  // A frame starts from idle on a strobe, or back-to-back out of S_DONE when
  // a strobe was queued during the previous frame (or arrives in S_DONE).
  assign start = ((fsm_q == S_IDLE) && gpu_en) ||
                 ((fsm_q == S_DONE) && (pending_q || gpu_en));

  assign last_word = (row_q == ROW_W'(CANVAS_H - 1)) &&
                     (col_q == COL_W'(COLS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q        <= S_IDLE;
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
      snap_dy_q    <= '0;
      snap_ox_q    <= '0;
      snap_st_q    <= '0;
      addr_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (start) begin
        fsm_q     <= S_DRAW;
        fb_we_q   <= 1'b1;
        pending_q <= 1'b0;
        snap_dy_q <= dino_y;
        snap_ox_q <= obstacle_x;
        snap_st_q <= state;
        addr_q    <= '0;
        row_q     <= '0;
        col_q     <= '0;
      end else begin
        case (fsm_q)
          S_DRAW: begin
            // One-deep queue: a second strobe while pending is simply lost.
            if (gpu_en) pending_q <= 1'b1;
            if (fb_ready) begin
              if (last_word) begin
                fsm_q        <= S_DONE;
                fb_we_q      <= 1'b0;
                frame_done_q <= 1'b1;
                addr_q       <= '0;
                row_q        <= '0;
                col_q        <= '0;
              end else begin
                addr_q <= addr_q + 11'd1;
                if (col_q == COL_W'(COLS - 1)) begin
                  col_q <= '0;
                  row_q <= row_q + 1'b1;
                end else begin
                  col_q <= col_q + 1'b1;
                end
              end
            end
          end
          S_DONE:  fsm_q <= S_IDLE;
          default: fsm_q <= S_IDLE;
        endcase
      end
    end
  end

  // Pixel generation for the word at (row_q, col_q).
  logic [5:0]       dino_d;
  logic [ROW_W-1:0] dino_top;
  logic [ROW_W-1:0] dino_bot;
  logic [9:0]       ox_lo;
  logic [9:0]       ox_hi;
  logic [9:0]       px_x;
  logic             ground_row;
  logic             dino_hit;
  logic             obst_row;
  logic [15:0]      obst_bits;
  logic [15:0]      base_bits;

  always_comb begin
    dino_d     = (snap_dy_q > 7'd44) ? 6'd44 : snap_dy_q[5:0];
    dino_top   = ROW_W'(DINO_TOP) - ROW_W'(dino_d);
    dino_bot   = ROW_W'(DINO_BOT) - ROW_W'(dino_d);
    ground_row = (row_q == ROW_W'(GROUND_ROW));
    dino_hit   = (row_q >= dino_top) && (row_q <= dino_bot) &&
                 (col_q == COL_W'(1));
    obst_row   = (row_q >= ROW_W'(OBST_TOP)) && (row_q <= ROW_W'(OBST_BOT));
    // 10-bit span so obstacle_x+7 never wraps; clipping at the right edge
    // also removes obstacles that start off-canvas.
    ox_lo      = {1'b0, snap_ox_q};
    ox_hi      = ox_lo + 10'd7;
    px_x       = '0;
    obst_bits  = '0;
    for (int i = 0; i < 16; i++) begin
      px_x         = 10'({col_q, 4'(15 - i)});
      obst_bits[i] = obst_row && (px_x >= ox_lo) && (px_x <= ox_hi) &&
                     (px_x <= 10'(CANVAS_W - 1));
    end
    base_bits = {16{ground_row}} | {16{dino_hit}};
    case (snap_st_q)
      2'b00:   fb_data = base_bits;
      2'b01:   fb_data = base_bits | obst_bits;
      2'b10:   fb_data = ~(base_bits | obst_bits);
      default: fb_data = 16'h0000;
    endcase
  end

  assign fb_we       = fb_we_q;
  assign fb_addr     = addr_q;
  assign busy        = (fsm_q != S_IDLE);
  assign frame_done  = frame_done_q;
  assign dbg_state_o = fsm_q;

endmodule

// File: tb/tb_gpu_draw.sv
// Bench for gpu_draw: directed frames with hand-computed spot words, plus a
// painted-bitmap reference frame pushed into an expected queue that a
// negedge monitor pops on every accepted write.
module tb_gpu_draw;

  localparam int W = 320;
  localparam int H = 64;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gpu_en = 1'b0;
  logic [6:0]  dino_y = '0;
  logic [8:0]  obstacle_x = '0;
  logic [1:0]  state = '0;
  logic        fb_ready = 1'b0;
  logic        fb_we;
  logic [10:0] fb_addr;
  logic [15:0] fb_data;
  logic        busy;
  logic        frame_done;
  logic [1:0]  dbg_state_o;

  always #5 clk = ~clk;

  gpu_draw #(.CANVAS_W(W), .CANVAS_H(H)) dut (
    .clk(clk), .rst(rst), .gpu_en(gpu_en), .dino_y(dino_y),
    .obstacle_x(obstacle_x), .state(state), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .busy(busy), .frame_done(frame_done), .dbg_state_o(dbg_state_o)
  );

  // Scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [26:0] exp_q[$];
  logic [10:0] spot_a[$];
  logic [15:0] spot_v[$];
  int          done_count = 0;
  int          words_in_frame = 0;
  int          last_acc_addr = -1;
  logic        expect_done = 1'b0;
  logic        chk_b2b = 1'b0;
  logic        hold_v = 1'b0;
  logic [10:0] hold_a = '0;
  logic [15:0] hold_d = '0;
  logic        rand_ready = 1'b0;
  logic        ready_fix = 1'b1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Ready driver
  always @(posedge clk) begin
    #1;
    fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // Reference frame: paint shapes into a bitmap, then pack into words.
  task automatic push_frame(input int dy, input int ox, input int st);
    logic [W-1:0] pix [H];
    logic [15:0]  w;
    int           d;
    for (int r = 0; r < H; r++) pix[r] = '0;
    if (st != 3) begin
      pix[60] = '1;
      d = (dy > 44) ? 44 : dy;
      for (int r = 44 - d; r <= 59 - d; r++)
        for (int x = 16; x <= 31; x++) pix[r][x] = 1'b1;
    end
    if (st == 1 || st == 2)
      for (int r = 48; r <= 59; r++)
        for (int x = ox; x <= ox + 7; x++)
          if (x < W) pix[r][x] = 1'b1;
    if (st == 2)
      for (int r = 0; r < H; r++) pix[r] = ~pix[r];
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W / 16; c++) begin
        for (int b = 0; b < 16; b++) w[15 - b] = pix[r][c * 16 + b];
        exp_q.push_back({11'(r * 20 + c), w});
      end
  endtask

  task automatic add_spot(input int a, input logic [15:0] v);
    spot_a.push_back(11'(a));
    spot_v.push_back(v);
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [26:0] e;
    if (!rst) begin
      expect_done    = 1'b0;
      chk_b2b        = 1'b0;
      hold_v         = 1'b0;
      words_in_frame = 0;
    end else begin
      if (chk_b2b) begin
        check("b2b_we", 32'(fb_we), 32'd1);
        check("b2b_addr", 32'(fb_addr), 32'd0);
        chk_b2b = 1'b0;
      end
      check("frame_done", 32'(frame_done), 32'(expect_done));
      if (expect_done) begin
        check("words_per_frame", words_in_frame, 1280);
        check("done_we_low", 32'(fb_we), 32'd0);
        words_in_frame = 0;
        done_count++;
        if (exp_q.size() > 0) chk_b2b = 1'b1;
        expect_done = 1'b0;
      end
      if (fb_we) begin
        check("dbg_state_draw", 32'(dbg_state_o), 32'd1);
        if (hold_v) begin
          check("hold_addr", 32'(fb_addr), 32'(hold_a));
          check("hold_data", 32'(fb_data), 32'(hold_d));
        end
        if (fb_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d expected none", fb_addr);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(fb_addr), 32'(e[26:16]));
            check("wr_data", 32'(fb_data), 32'(e[15:0]));
          end
          for (int k = 0; k < spot_a.size(); k++)
            if (spot_a[k] == fb_addr) begin
              check($sformatf("spot_%0d", fb_addr), 32'(fb_data), 32'(spot_v[k]));
              spot_a.delete(k);
              spot_v.delete(k);
              break;
            end
          words_in_frame++;
          last_acc_addr = int'(fb_addr);
          if (fb_addr == 11'd1279) expect_done = 1'b1;
        end
        hold_v = !fb_ready;
        hold_a = fb_addr;
        hold_d = fb_data;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic pulse_en();
    @(posedge clk); #1 gpu_en = 1'b1;
    @(posedge clk); #1 gpu_en = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, done_count, target);
  endtask

  task automatic wait_words(input int a, input int budget, input string name);
    int n = 0;
    while (last_acc_addr < a && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(last_acc_addr >= a), 32'd1);
  endtask

  task automatic check_idle(input int cycles, input string name);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (fb_we || busy) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic start_frame(input int dy, input int ox, input int st);
    dino_y = 7'(dy);
    obstacle_x = 9'(ox);
    state = 2'(st);
    push_frame(dy, ox, st);
    last_acc_addr = -1;
    pulse_en();
  endtask

  initial begin
    int base;
    // Reset state
    #1 rst = 1'b0;
    #3;
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_dbg_state", 32'(dbg_state_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_idle(3, "idle_after_reset");

    // Run frame: ground, dino at rest, obstacle at x=100
    add_spot(20 * 44 + 1, 16'hFFFF);
    add_spot(20 * 48 + 6, 16'h0FF0);
    for (int a = 1200; a <= 1219; a++) add_spot(a, 16'hFFFF);
    start_frame(0, 100, 1);
    wait_done(1, 1400, "frame1_done");
    check("frame1_spots_hit", spot_a.size(), 0);
    check_idle(4, "idle_after_frame1");

    // Game over frame: inverted, obstacle clipped at right edge
    add_spot(8 * 20 + 1, 16'h0000);
    add_spot(20 * 50 + 19, 16'hFFF0);
    add_spot(1260, 16'hFFFF);
    start_frame(36, 316, 2);
    wait_done(2, 1400, "frame2_done");
    check("frame2_spots_hit", spot_a.size(), 0);

    // Random backpressure
    rand_ready = 1'b1;
    start_frame(20, 200, 1);
    wait_done(3, 8000, "frame3_done");
    start_frame(50, 0, 0);
    wait_done(4, 8000, "frame4_done");
    rand_ready = 1'b0;
    ready_fix = 1'b1;
    @(posedge clk);

    // Pending restart: first frame keeps snapshot, one extra frame, third
    // strobe dropped
    start_frame(10, 150, 1);
    wait_words(100, 400, "pend_reach_100");
    dino_y = 7'd30;
    push_frame(30, 150, 1);
    pulse_en();
    wait_words(500, 800, "pend_reach_500");
    pulse_en();
    wait_done(6, 3000, "pend_two_frames");
    check_idle(30, "pend_third_dropped");

    // Reset mid-frame
    start_frame(5, 60, 1);
    wait_words(600, 800, "rst_reach_600");
    base = done_count;
    #2 rst = 1'b0;
    #1;
    check("midrst_fb_we", 32'(fb_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_fb_addr", 32'(fb_addr), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    gpu_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 gpu_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    check_idle(5, "en_ignored_in_reset");
    check("midrst_no_done", done_count, base);
    start_frame(5, 60, 1);
    wait_done(base + 1, 1400, "post_rst_frame");

    // Reserved state blanks everything; run state hides off-canvas obstacle
    start_frame(127, 511, 3);
    wait_done(base + 2, 1400, "blank_frame");
    for (int r = 0; r < 16; r++) add_spot(r * 20 + 1, 16'hFFFF);
    add_spot(20 * 48 + 19, 16'h0000);
    add_spot(16 * 20 + 1, 16'h0000);
    start_frame(127, 511, 1);
    wait_done(base + 3, 1400, "clamp_frame");
    check("clamp_spots_hit", spot_a.size(), 0);
    check("queue_drained", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
